multi_cycle_controller: RTL and testbench

Multi-cycle control FSM for the RV32I subset datapath. It drives the ALU operator code and datapath select and enable lines, and consumes the ALU's zero and less flags to resolve branches. One instruction spans 3–5+ states. Memory accesses use a ready handshake, so instruction and data memory may insert wait states.

---
 rtl/cpu_ctrl_pkg.sv | 72 +++++++
 rtl/alu_op_decoder.sv | 60 ++++++
 rtl/multi_cycle_controller.sv | 173 +++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multi-cycle RV32I control FSM
package cpu_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_ILLEGAL  = 4'd11;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] A_PC    = 2'd0;
    localparam logic [1:0] A_OLDPC = 2'd1;
    localparam logic [1:0] A_RS1   = 2'd2;

    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLTU = 3'b110;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm_sel;
    } ctrl_t;

    // Only legal branch funct3 values reach BRANCH, so anything else is bgeu.
    function automatic logic branch_taken(logic [2:0] f3, logic zero, logic less);
        return (f3 == F3_BEQ) ? zero : (f3 == F3_BNE) ? !zero : (f3 == F3_BLTU) ? less : !less;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps opcode/funct3/funct7 to an ALU operator and a legal bit
module alu_op_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [2:0] o_alu_op,
    output logic       o_legal
);

    logic [2:0] w_base_op;
    logic       w_base_ok;
    logic       w_shift;
    logic       w_f7_zero;
    logic       w_f7_alt;

    assign w_shift   = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    assign w_f7_zero = (i_funct7 == 7'b0000000);
    assign w_f7_alt  = (i_funct7 == 7'b0100000);
    assign w_base_ok = (i_funct3 != 3'b010) && (i_funct3 != 3'b011);

    // Operator shared by R-type and I-type ALU forms; slt/sltu have no ALU op here.
    always_comb begin
        w_base_op = OP_ADD;
        case (i_funct3)
            3'b001:  w_base_op = OP_SLL;
            3'b100:  w_base_op = OP_XOR;
            3'b101:  w_base_op = OP_SRL;
            3'b110:  w_base_op = OP_OR;
            3'b111:  w_base_op = OP_AND;
            default: w_base_op = OP_ADD;
        endcase
    end

    // Per-opcode legality; funct7=0100000 is legal only as sub (sra/srai rejected).
    always_comb begin
        o_alu_op = OP_ADD;
        o_legal  = 1'b0;
        case (i_opcode)
            OPC_R: begin
                o_alu_op = (i_funct3 == 3'b000 && i_funct7[5]) ? OP_SUB : w_base_op;
                o_legal  = w_base_ok && (w_f7_zero || (w_f7_alt && i_funct3 == 3'b000));
            end
            OPC_I: begin
                o_alu_op = w_base_op;
                o_legal  = w_base_ok && (!w_shift || w_f7_zero);
            end
            OPC_LOAD, OPC_STORE: o_legal = (i_funct3 == 3'b010);
            OPC_BRANCH: begin
                o_alu_op = OP_SUB;
                o_legal  = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                           (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
            end
            OPC_JAL: o_legal = 1'b1;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: multi-cycle control FSM for the RV32I subset datapath
module multi_cycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3
)(
    input  logic                ClkIn,
    input  logic                RstnIn,
    input  logic [31:0]         InstrIn,
    input  logic                MemReadyIn,
    input  logic                ZeroIn,
    input  logic                LessIn,
    output logic                PCWriteOut,
    output logic                PCSrcOut,
    output logic                IRWriteOut,
    output logic                IorDOut,
    output logic                MemReadOut,
    output logic                MemWriteOut,
    output logic                RegWriteOut,
    output logic [1:0]          WBSelOut,
    output logic [1:0]          ALUSrcAOut,
    output logic [1:0]          ALUSrcBOut,
    output logic [2:0]          ImmSelOut,
    output logic [ALU_OP_W-1:0] ALUOpOut,
    output logic [3:0]          StateOut,
    output logic                IllegalOut
);

    logic [3:0] r_state;
    logic       r_illegal;
    logic [3:0] w_next;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [2:0] w_dec_op;
    logic [2:0] w_op;
    logic       w_legal;
    ctrl_t      w_ctrl;
    logic       w_unused;

    assign w_opcode = InstrIn[6:0];
    assign w_funct3 = InstrIn[14:12];
    assign w_funct7 = InstrIn[31:25];
    assign w_unused = &{1'b0, InstrIn[24:15], InstrIn[11:7]};

    alu_op_decoder u_dec (
        .i_opcode (w_opcode),
        .i_funct3 (w_funct3),
        .i_funct7 (w_funct7),
        .o_alu_op (w_dec_op),
        .o_legal  (w_legal)
    );

    // Next-state: memory states wait on MemReadyIn, DECODE dispatches on opcode.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = MemReadyIn ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = !w_legal                ? S_ILLEGAL  :
                                 (w_opcode == OPC_R)      ? S_EXEC_R   :
                                 (w_opcode == OPC_I)      ? S_EXEC_I   :
                                 (w_opcode == OPC_LOAD ||
                                  w_opcode == OPC_STORE)  ? S_MEM_ADDR :
                                 (w_opcode == OPC_BRANCH) ? S_BRANCH   :
                                 (w_opcode == OPC_JAL)    ? S_JAL      : S_ILLEGAL;
            S_EXEC_R:   w_next = S_WB_ALU;
            S_EXEC_I:   w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = (w_opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = MemReadyIn ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   w_next = MemReadyIn ? S_FETCH : S_MEM_WR;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_FETCH;
        endcase
    end

    // State register plus sticky illegal flag, set on the transition into ILLEGAL.
    always_ff @(posedge ClkIn or negedge RstnIn) begin
        if (!RstnIn) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_ILLEGAL);
        end
    end

    // Per-state control decode; reset gates everything to idle so an aborted
    // instruction cannot leave a partial register or memory write behind.
    always_comb begin
        w_ctrl = '0;
        w_op   = OP_ADD;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.src_a    = A_PC;
                w_ctrl.src_b    = B_FOUR;
                w_ctrl.ir_write = MemReadyIn;
                w_ctrl.pc_write = MemReadyIn;
            end
            S_DECODE: begin
                w_ctrl.src_a   = A_OLDPC;
                w_ctrl.src_b   = B_IMM;
                w_ctrl.imm_sel = (w_opcode == OPC_BRANCH) ? IMM_B : (w_opcode == OPC_JAL) ? IMM_J : IMM_I;
            end
            S_EXEC_R: begin
                w_ctrl.src_a = A_RS1;
                w_ctrl.src_b = B_RS2;
                w_op         = w_dec_op;
            end
            S_EXEC_I: begin
                w_ctrl.src_a   = A_RS1;
                w_ctrl.src_b   = B_IMM;
                w_ctrl.imm_sel = IMM_I;
                w_op           = w_dec_op;
            end
            S_MEM_ADDR: begin
                w_ctrl.src_a   = A_RS1;
                w_ctrl.src_b   = B_IMM;
                w_ctrl.imm_sel = (w_opcode == OPC_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
            end
            S_WB_ALU: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_sel    = WB_ALUOUT;
            end
            S_WB_MEM: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_sel    = WB_MDR;
            end
            S_BRANCH: begin
                w_ctrl.src_a    = A_RS1;
                w_ctrl.src_b    = B_RS2;
                w_ctrl.pc_src   = 1'b1;
                w_ctrl.pc_write = branch_taken(w_funct3, ZeroIn, LessIn);
                w_op            = OP_SUB;
            end
            S_JAL: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.wb_sel    = WB_PC;
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_src    = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
        if (!RstnIn) begin
            w_ctrl = '0;
            w_op   = OP_ADD;
        end
    end

    assign PCWriteOut  = w_ctrl.pc_write;
    assign PCSrcOut    = w_ctrl.pc_src;
    assign IRWriteOut  = w_ctrl.ir_write;
    assign IorDOut     = w_ctrl.iord;
    assign MemReadOut  = w_ctrl.mem_read;
    assign MemWriteOut = w_ctrl.mem_write;
    assign RegWriteOut = w_ctrl.reg_write;
    assign WBSelOut    = w_ctrl.wb_sel;
    assign ALUSrcAOut  = w_ctrl.src_a;
    assign ALUSrcBOut  = w_ctrl.src_b;
    assign ImmSelOut   = w_ctrl.imm_sel;
    assign ALUOpOut    = ALU_OP_W'(w_op);
    assign StateOut    = r_state;
    assign IllegalOut  = r_illegal;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: directed scoreboard bench for the control FSM
module tb_multi_cycle_controller;

    localparam logic [3:0] FE = 4'd0, DE = 4'd1, XR = 4'd2, XI = 4'd3, MA = 4'd4, MR = 4'd5;
    localparam logic [3:0] MW = 4'd6, WA = 4'd7, WM = 4'd8, BR = 4'd9, JA = 4'd10, IL = 4'd11;
    localparam logic [2:0] ADD = 3'd1, SUB = 3'd2, AND = 3'd3, XOR = 3'd5, SRL = 3'd7;

    typedef logic [23:0] vec_t;
    localparam vec_t M_ALL  = 24'hFFFFFF;
    localparam vec_t M_CORE = 24'hFAE001;
    localparam vec_t M_PCS  = 24'h040000;
    localparam vec_t M_IORD = 24'h010000;
    localparam vec_t M_WB   = 24'h001800;
    localparam vec_t M_A    = 24'h000600;
    localparam vec_t M_B    = 24'h000180;
    localparam vec_t M_IMM  = 24'h000070;
    localparam vec_t M_OP   = 24'h00000E;

    logic        ClkIn, RstnIn, MemReadyIn, ZeroIn, LessIn;
    logic [31:0] InstrIn;
    logic        PCWriteOut, PCSrcOut, IRWriteOut, IorDOut, MemReadOut, MemWriteOut, RegWriteOut;
    logic [1:0]  WBSelOut, ALUSrcAOut, ALUSrcBOut;
    logic [2:0]  ImmSelOut, ALUOpOut;
    logic [3:0]  StateOut;
    logic        IllegalOut;

    vec_t  q_exp[$];
    vec_t  q_msk[$];
    string q_tag[$];
    int    n_vec = 0;
    int    n_bad = 0;

    multi_cycle_controller #(.ALU_OP_W(3)) dut (
        .ClkIn(ClkIn), .RstnIn(RstnIn), .InstrIn(InstrIn), .MemReadyIn(MemReadyIn),
        .ZeroIn(ZeroIn), .LessIn(LessIn), .PCWriteOut(PCWriteOut), .PCSrcOut(PCSrcOut),
        .IRWriteOut(IRWriteOut), .IorDOut(IorDOut), .MemReadOut(MemReadOut),
        .MemWriteOut(MemWriteOut), .RegWriteOut(RegWriteOut), .WBSelOut(WBSelOut),
        .ALUSrcAOut(ALUSrcAOut), .ALUSrcBOut(ALUSrcBOut), .ImmSelOut(ImmSelOut),
        .ALUOpOut(ALUOpOut), .StateOut(StateOut), .IllegalOut(IllegalOut)
    );

    initial ClkIn = 1'b0;
    always #5 ClkIn = ~ClkIn;

    function automatic vec_t obs();
        return {StateOut, PCWriteOut, PCSrcOut, IRWriteOut, IorDOut, MemReadOut, MemWriteOut,
                RegWriteOut, WBSelOut, ALUSrcAOut, ALUSrcBOut, ImmSelOut, ALUOpOut, IllegalOut};
    endfunction

    // en = {PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, RegWrite}
    function automatic vec_t ev(logic [3:0] st, logic [6:0] en, logic [1:0] wb, logic [1:0] a,
                                logic [1:0] b, logic [2:0] imm, logic [2:0] op, logic ill);
        return {st, en, wb, a, b, imm, op, ill};
    endfunction

    task automatic push(string t, vec_t e, vec_t m);
        q_tag.push_back(t);
        q_exp.push_back(e);
        q_msk.push_back(m);
    endtask

    task automatic chk();
        while (q_exp.size() > 0) begin
            vec_t  e, m, o;
            string t;
            e = q_exp.pop_front();
            m = q_msk.pop_front();
            t = q_tag.pop_front();
            o = obs();
            n_vec++;
            assert ((o & m) === (e & m)) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h (mask %h)", t, o & m, e & m, m);
            end
        end
    endtask

    task automatic cyc();
        @(negedge ClkIn);
        chk();
        @(posedge ClkIn);
        #1;
    endtask

    task automatic rnd_ready();
        MemReadyIn = 1'($urandom_range(0, 1));
    endtask

    task automatic e_rst(string t);
        push(t, ev(FE, 7'b0, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b0), M_ALL);
    endtask

    task automatic e_fetch(logic rdy);
        push("fetch", ev(FE, {rdy, 1'b0, rdy, 1'b0, 1'b1, 1'b0, 1'b0}, 2'd0, 2'd0, 2'd2, 3'd0, ADD, 1'b0),
             M_CORE | M_PCS | M_IORD | M_A | M_B | M_OP);
    endtask

    task automatic e_dec(string t, logic [2:0] imm, logic care);
        push(t, ev(DE, 7'b0, 2'd0, 2'd1, 2'd1, imm, ADD, 1'b0),
             M_CORE | M_A | M_B | M_OP | (care ? M_IMM : 24'h0));
    endtask

    task automatic run_r(string t, logic [31:0] ins, logic [2:0] op);
        InstrIn = ins; MemReadyIn = 1'b1;
        e_fetch(1'b1); cyc();
        rnd_ready(); e_dec(t, 3'd0, 1'b0); cyc();
        rnd_ready(); push(t, ev(XR, 7'b0, 2'd0, 2'd2, 2'd0, 3'd0, op, 1'b0), M_CORE | M_A | M_B | M_OP); cyc();
        rnd_ready(); push(t, ev(WA, 7'b0000001, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b0), M_CORE | M_WB); cyc();
    endtask

    task automatic run_i(string t, logic [31:0] ins, logic [2:0] op);
        InstrIn = ins; MemReadyIn = 1'b1;
        e_fetch(1'b1); cyc();
        rnd_ready(); e_dec(t, 3'd0, 1'b0); cyc();
        rnd_ready(); push(t, ev(XI, 7'b0, 2'd0, 2'd2, 2'd1, 3'd0, op, 1'b0), M_CORE | M_A | M_B | M_IMM | M_OP); cyc();
        rnd_ready(); push(t, ev(WA, 7'b0000001, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b0), M_CORE | M_WB); cyc();
    endtask

    task automatic run_br(string t, logic [31:0] ins, logic z, logic l, logic taken);
        InstrIn = ins; MemReadyIn = 1'b1; ZeroIn = z; LessIn = l;
        e_fetch(1'b1); cyc();
        rnd_ready(); e_dec(t, 3'd2, 1'b1); cyc();
        rnd_ready(); push(t, ev(BR, {taken, 1'b1, 5'b0}, 2'd0, 2'd2, 2'd0, 3'd0, SUB, 1'b0),
                          M_CORE | M_PCS | M_A | M_B | M_OP); cyc();
    endtask

    task automatic e_illegal(string t);
        push(t, ev(IL, 7'b0, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b1), M_CORE);
    endtask

    initial begin
        RstnIn = 1'b0; InstrIn = 32'h0; MemReadyIn = 1'b0; ZeroIn = 1'b0; LessIn = 1'b0;
        e_rst("reset"); cyc();
        RstnIn = 1'b1;
        e_fetch(1'b0); cyc();

        run_r("add", 32'h002081B3, ADD);
        run_r("sub", 32'h402081B3, SUB);
        run_r("and", 32'h0020F1B3, AND);
        run_i("srli", 32'h0030D093, SRL);
        run_i("xori", 32'hFFF0C113, XOR);

        InstrIn = 32'h0080A283; MemReadyIn = 1'b1;
        e_fetch(1'b1); cyc();
        e_dec("lw", 3'd0, 1'b0); cyc();
        push("lw_addr", ev(MA, 7'b0, 2'd0, 2'd2, 2'd1, 3'd0, ADD, 1'b0), M_CORE | M_A | M_B | M_IMM | M_OP); cyc();
        for (int i = 0; i < 3; i++) begin
            MemReadyIn = (i == 2);
            push("lw_rd", ev(MR, 7'b0001100, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b0), M_CORE | M_IORD); cyc();
        end
        rnd_ready();
        push("lw_wb", ev(WM, 7'b0000001, 2'd1, 2'd0, 2'd0, 3'd0, ADD, 1'b0), M_CORE | M_WB); cyc();

        InstrIn = 32'h0020A223; MemReadyIn = 1'b1;
        e_fetch(1'b1); cyc();
        e_dec("sw", 3'd0, 1'b0); cyc();
        push("sw_addr", ev(MA, 7'b0, 2'd0, 2'd2, 2'd1, 3'd1, ADD, 1'b0), M_CORE | M_A | M_B | M_IMM | M_OP); cyc();
        push("sw_wr", ev(MW, 7'b0001010, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b0), M_CORE | M_IORD); cyc();

        run_br("beq_t", 32'h00208063, 1'b1, 1'b0, 1'b1);
        run_br("beq_n", 32'h00208063, 1'b0, 1'b0, 1'b0);
        run_br("bne_t", 32'h00209063, 1'b0, 1'b1, 1'b1);
        run_br("bltu_t", 32'h0020E063, 1'b0, 1'b1, 1'b1);
        run_br("bgeu_n", 32'h0020F063, 1'b1, 1'b1, 1'b0);
        run_br("bgeu_t", 32'h0020F063, 1'b0, 1'b0, 1'b1);

        InstrIn = 32'h000000EF; MemReadyIn = 1'b1;
        e_fetch(1'b1); cyc();
        rnd_ready(); e_dec("jal", 3'd3, 1'b1); cyc();
        rnd_ready(); push("jal", ev(JA, 7'b1100001, 2'd2, 2'd0, 2'd0, 3'd0, ADD, 1'b0), M_CORE | M_PCS | M_WB); cyc();

        InstrIn = 32'h0020A223; MemReadyIn = 1'b1;
        e_fetch(1'b1); cyc();
        e_dec("sw2", 3'd0, 1'b0); cyc();
        push("sw2_addr", ev(MA, 7'b0, 2'd0, 2'd2, 2'd1, 3'd1, ADD, 1'b0), M_CORE | M_A | M_B | M_IMM | M_OP); cyc();
        MemReadyIn = 1'b0;
        push("sw2_wait", ev(MW, 7'b0001010, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b0), M_CORE | M_IORD); cyc();
        push("sw2_hold", ev(MW, 7'b0001010, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b0), M_CORE | M_IORD); chk();
        #2 RstnIn = 1'b0;
        #1 e_rst("rst_abort"); chk();
        MemReadyIn = 1'b1;
        e_rst("rst_hold"); cyc();
        RstnIn = 1'b1; MemReadyIn = 1'b0;
        e_fetch(1'b0); cyc();

        InstrIn = 32'h00000000; MemReadyIn = 1'b1;
        e_fetch(1'b1); cyc();
        e_dec("ill_dec", 3'd0, 1'b0); cyc();
        for (int i = 0; i < 10; i++) begin
            rnd_ready(); e_illegal("illegal"); cyc();
        end
        RstnIn = 1'b0;
        #1 e_rst("rst_ill"); chk();
        @(posedge ClkIn); #1;
        RstnIn = 1'b1;

        InstrIn = 32'h40105093; MemReadyIn = 1'b1;
        e_fetch(1'b1); cyc();
        e_dec("srai_dec", 3'd0, 1'b0); cyc();
        e_illegal("srai"); cyc();
        e_illegal("srai"); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
